motor_step_gen: RTL and testbench

Step/direction pulse generator that sits directly downstream of the motor 14-bit PIO command register. It consumes the 14-bit `out_port` command word and converts each start request into a counted burst of step pulses with a direction-setup delay. It also keeps a signed step-position count. Its outputs drive the external stepper driver pins and can be read back by software through a companion input PIO.

---
 rtl/motor_step_gen.sv | 173 +++++++++++++++++
 tb/tb_motor_step_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_step_gen.sv
// motor_step_gen
// Converts a 14-bit PIO command word {go, dir, N[11:0]} into a burst of N step
// pulses. A direction-setup delay comes before the first pulse, and the block
// keeps a signed 16-bit position count that wraps modulo 2^16.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a rising edge of go (go held high does not restart)
// SETUP | dir is driven, waiting before the first step rising edge
// HIGH  | step high for HALF_PERIOD cycles; position moved on entry
// LOW   | step low for HALF_PERIOD cycles; step count consumed at the end
// FIN   | one-cycle done pulse, busy already low
//
// The first SETUP cycle is the accept cycle in which dir settles on the pin.
// SETUP is therefore loaded with DIR_SETUP, which gives DIR_SETUP+1 cycles in
// SETUP, and the first rising edge of step lands DIR_SETUP edges after the
// edge where busy and dir are already valid.
// A zero-length move also passes through that accept cycle, with a zero
// count, so its done pulse falls one edge after the start.

module motor_step_gen #(
    parameter int HALF_PERIOD = 25000,
    parameter int DIR_SETUP   = 50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] cmd,
    output logic        step,
    output logic        dir,
    output logic        busy,
    output logic        done,
    output logic [15:0] position
);

    localparam int MAX_CNT = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HP_LOAD    = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t            state;
    logic              go_q;
    logic              armed;
    logic              abort_pend;
    logic [CNT_W-1:0]  cnt;
    logic [11:0]       remaining;

    logic              go;
    logic              start_evt;
    logic [11:0]       remaining_dec;
    logic [15:0]       position_step;

    assign go            = cmd[13];
    // After reset, armed stays low until go has been seen low, so a go level
    // held high through reset release cannot start a move.
    assign start_evt     = go && !go_q && armed && (state == IDLE);
    assign remaining_dec = remaining - 12'd1;
    assign position_step = dir ? (position + 16'd1) : (position - 16'd1);

    // Sequencer: phase counting, step/dir/busy/done outputs and position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            go_q       <= 1'b0;
            armed      <= 1'b0;
            abort_pend <= 1'b0;
            cnt        <= '0;
            remaining  <= '0;
            step       <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            position   <= '0;
        end else begin
            go_q <= go;
            done <= 1'b0;
            if (!go) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_evt) begin
                        dir        <= cmd[12];
                        remaining  <= cmd[11:0];
                        busy       <= 1'b1;
                        abort_pend <= 1'b0;
                        cnt        <= (cmd[11:0] == 12'd0) ? '0 : SETUP_LOAD;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    if (!go) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        if (remaining == 12'd0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            step     <= 1'b1;
                            position <= position_step;
                            cnt      <= HP_LOAD;
                            state    <= HIGH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                HIGH: begin
                    // An abort here is remembered so the pulse is never cut short.
                    if (!go) begin
                        abort_pend <= 1'b1;
                    end
                    if (cnt == '0) begin
                        step <= 1'b0;
                        if (abort_pend || !go) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt   <= HP_LOAD;
                            state <= LOW;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                LOW: begin
                    if (!go) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        remaining <= remaining_dec;
                        if (remaining_dec == 12'd0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            step     <= 1'b1;
                            position <= position_step;
                            cnt      <= HP_LOAD;
                            state    <= HIGH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    step  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_step_gen.sv
// Testbench for motor_step_gen. The main instance runs with HALF_PERIOD=4 and
// DIR_SETUP=2. It is compared cycle by cycle against an arithmetic timeline
// model of each move. A second, fast instance with HALF_PERIOD=1 and
// DIR_SETUP=1 walks the position counter up to the signed 16-bit boundary.
`timescale 1ns/1ps

module tb_motor_step_gen;

    localparam int H  = 4;
    localparam int D  = 2;
    localparam int T0 = 1 + D;
    localparam int P  = 2 * H;

    logic        clk;
    logic        reset_n;
    logic [13:0] cmd;
    logic        step, dir, busy, done;
    logic [15:0] position;

    logic [13:0] cmd2;
    logic        step2, dir2, busy2, done2;
    logic [15:0] position2;

    int          checks;
    int          errors;
    logic [15:0] pos_model;
    logic [15:0] wrap_model;

    motor_step_gen #(.HALF_PERIOD(H), .DIR_SETUP(D)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd      (cmd),
        .step     (step),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .position (position)
    );

    motor_step_gen #(.HALF_PERIOD(1), .DIR_SETUP(1)) u_wrap (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd      (cmd2),
        .step     (step2),
        .dir      (dir2),
        .busy     (busy2),
        .done     (done2),
        .position (position2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stops the run with a FAIL line if the bench ever stops making progress.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Timeline model, with edges counted from the start edge (edge 0).
    function automatic int end_edge(input int n);
        return (n == 0) ? 1 : T0 + P * n;
    endfunction

    function automatic bit in_high(input int t, input int n);
        return (n > 0) && (t >= T0) && (t < end_edge(n)) && (((t - T0) % P) < H);
    endfunction

    function automatic int started(input int t, input int n);
        int c;
        if (n == 0 || t < T0) return 0;
        c = (t - T0) / P + 1;
        return (c > n) ? n : c;
    endfunction

    // Edge at which an abort sampled at edge a takes effect.
    function automatic int stop_edge(input int n, input int a);
        if (in_high(a - 1, n))
            return T0 + ((a - 1 - T0) / P) * P + H;
        return a;
    endfunction

    // One move on the main instance. a = 0 means no abort; otherwise go is
    // sampled low at edge a. Outputs are checked after every edge.
    task automatic run_move(input int n, input bit d, input int a);
        int          e, last, ns;
        bit          es, eb, ed;
        logic [15:0] epos;
        e    = (a > 0) ? stop_edge(n, a) : 32'h4000_0000;
        last = (a > 0) ? e + 3 : end_edge(n) + 4;
        epos = pos_model;
        @(negedge clk) cmd = 14'h0000;
        @(negedge clk) cmd = {1'b1, d, 12'(n)};
        for (int t = 0; t <= last; t++) begin
            @(posedge clk);
            #1;
            if (t >= 1) begin
                if (t >= e) begin
                    es = 1'b0; eb = 1'b0; ed = 1'b0;
                    ns = started(e - 1, n);
                end else begin
                    es = in_high(t, n);
                    eb = (t < end_edge(n));
                    ed = (t == end_edge(n));
                    ns = started(t, n);
                end
                epos = d ? (pos_model + 16'(ns)) : (pos_model - 16'(ns));
                check("step", {31'd0, step}, {31'd0, es});
                check("busy", {31'd0, busy}, {31'd0, eb});
                check("done", {31'd0, done}, {31'd0, ed});
                check("dir", {31'd0, dir}, {31'd0, d});
                check("position", {16'd0, position}, {16'd0, epos});
                if (a > 0 && t == a - 1)
                    cmd[13] = 1'b0;
                if (cmd[13] && eb)
                    cmd[12:0] = 13'($urandom);
            end
        end
        pos_model = epos;
    endtask

    // One move on the fast instance; waits for done within a cycle budget.
    task automatic fast_move(input bit d, input int n);
        bit got;
        got = 1'b0;
        @(negedge clk) cmd2 = 14'h0000;
        @(negedge clk) cmd2 = {1'b1, d, 12'(n)};
        for (int i = 0; i < 2 * n + 20; i++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                got = 1'b1;
                break;
            end
        end
        check("wrap_done", {31'd0, got}, 32'd1);
        wrap_model = d ? (wrap_model + 16'(n)) : (wrap_model - 16'(n));
        @(negedge clk) cmd2 = 14'h0000;
    endtask

    initial begin
        int n, a;
        bit d;
        checks     = 0;
        errors     = 0;
        pos_model  = 16'h0000;
        wrap_model = 16'h0000;
        cmd        = 14'h0000;
        cmd2       = 14'h0000;
        reset_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_dir", {31'd0, dir}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_position", {16'd0, position}, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // Scenarios from the test plan.
        run_move(3, 1'b1, 0);
        check("plan_pos_3", {16'd0, position}, 32'd3);
        run_move(2, 1'b0, 0);
        check("plan_pos_1", {16'd0, position}, 32'd1);
        run_move(0, 1'b1, 0);
        check("plan_pos_n0", {16'd0, position}, 32'd1);
        run_move(5, 1'b1, 12);
        check("plan_pos_abort", {16'd0, position}, 32'd3);

        // Randomized moves, some of them aborted at a random edge.
        for (int k = 0; k < 24; k++) begin
            n = $urandom_range(0, 5);
            d = 1'($urandom_range(0, 1));
            a = 0;
            if (n > 0 && $urandom_range(0, 2) == 0)
                a = $urandom_range(2, end_edge(n));
            run_move(n, d, a);
        end

        // Asynchronous reset during the low phase of the second step.
        @(negedge clk) cmd = 14'h0000;
        @(negedge clk) cmd = 14'h3003;
        repeat (17) @(posedge clk);
        #1;
        check("pre_rst_step_low", {31'd0, step}, 32'd0);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_step", {31'd0, step}, 32'd0);
        check("async_rst_dir", {31'd0, dir}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_position", {16'd0, position}, 32'd0);
        pos_model = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("held_go_busy", {31'd0, busy}, 32'd0);
            check("held_go_step", {31'd0, step}, 32'd0);
        end

        // Stepping down from zero wraps to 0xFFFF.
        run_move(1, 1'b0, 0);
        check("wrap_down_ffff", {16'd0, position}, 32'h0000_FFFF);

        // Walk the fast instance up to 0x7FFF, then across the signed boundary.
        for (int k = 0; k < 8; k++)
            fast_move(1'b1, 4095);
        fast_move(1'b1, 7);
        check("wrap_pre_7fff", {16'd0, position2}, {16'd0, wrap_model});
        fast_move(1'b1, 1);
        check("wrap_up_8000", {16'd0, position2}, 32'h0000_8000);
        fast_move(1'b0, 1);
        check("wrap_back_7fff", {16'd0, position2}, 32'h0000_7FFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
